// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter sharing the RW port of a 1rw1r SRAM macro between two requesters,
// with a zero-fill init sequence after reset and fixed two-cycle read responses.

module sram_rw_port_arbiter_rsp #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  hit,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= hit;
      if (hit) rdata <= dout0;
    end
  end
endmodule

module sram_rw_port_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 8
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);
  localparam int NUM_REQ = 2;
  localparam int STAGES  = 2;

  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     init_cnt;
  logic                      prio;  // 0: A wins a tie, 1: B wins a tie
  req_t [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        vld, gnt, hit, rvalid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata;
  logic                      hs, sel;
  req_t                      win;
  logic [STAGES-1:0]         vld_pipe, id_pipe;

  assign req[0] = {a_we, a_wmask, a_addr, a_wdata};
  assign req[1] = {b_we, b_wmask, b_addr, b_wdata};
  assign vld    = {b_valid, a_valid};

  always_comb begin
    gnt = '0;
    if (state == S_RUN) begin
      gnt[0] = vld[0] & (~vld[1] | ~prio);
      gnt[1] = vld[1] & (~vld[0] |  prio);
    end
  end

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign hs      = |gnt;
  assign sel     = gnt[1];
  assign win     = req[sel];

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      prio      <= 1'b0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= '0;
      addr0     <= '0;
      din0      <= '0;
    end else begin
      case (state)
        S_INIT: begin
          csb0     <= 1'b0;
          web0     <= 1'b0;
          wmask0   <= '1;
          addr0    <= init_cnt;
          din0     <= '0;
          init_cnt <= init_cnt + ADDR_WIDTH'(1);
          if (init_cnt == '1) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (hs) begin
            csb0   <= 1'b0;
            web0   <= ~win.we;
            wmask0 <= win.wmask;
            addr0  <= win.addr;
            din0   <= win.wdata;
            prio   <= ~sel;
          end else begin
            csb0 <= 1'b1;
            web0 <= 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Read tags: macro samples one cycle after accept, data is captured one cycle later.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], hs & ~win.we};
      id_pipe  <= {id_pipe[STAGES-2:0], sel};
    end
  end

  assign hit = vld_pipe[STAGES-1] ? (NUM_REQ'(1) << id_pipe[STAGES-1]) : '0;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    sram_rw_port_arbiter_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
      .clk0   (clk0),
      .rst_n  (rst_n),
      .hit    (hit[g]),
      .dout0  (dout0),
      .rvalid (rvalid[g]),
      .rdata  (rdata[g])
    );
  end

  assign a_rvalid = rvalid[0];
  assign a_rdata  = rdata[0];
  assign b_rvalid = rvalid[1];
  assign b_rdata  = rdata[1];
endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Directed bench for sram_rw_port_arbiter with a behavioural model of the SRAM RW port.

module tb_sram_rw_port_arbiter;
  logic        clk0 = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, a_we, a_rvalid;
  logic [7:0]  a_wmask, a_addr;
  logic [63:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_we, b_rvalid;
  logic [7:0]  b_wmask, b_addr;
  logic [63:0] b_wdata, b_rdata;
  logic        init_done, csb0, web0;
  logic [7:0]  wmask0, addr0;
  logic [63:0] din0, dout0;

  always #5 clk0 = ~clk0;

  sram_rw_port_arbiter dut (
    .clk0(clk0), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0)
  );

  // Macro model: sample pins on posedge, act on the following negedge.
  logic [63:0] mem [0:255];
  logic        m_csb = 1'b1, m_web = 1'b1;
  logic [7:0]  m_mask, m_addr;
  logic [63:0] m_din;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'hA5A5_A5A5_A5A5_A5A5;
    dout0 = '0;
  end

  always @(posedge clk0) begin
    m_csb  <= csb0;
    m_web  <= web0;
    m_mask <= wmask0;
    m_addr <= addr0;
    m_din  <= din0;
  end

  always @(negedge clk0) begin
    if (!m_csb) begin
      if (!m_web) begin
        for (int k = 0; k < 8; k++)
          if (m_mask[k]) mem[m_addr][k*8 +: 8] = m_din[k*8 +: 8];
      end else begin
        dout0 <= mem[m_addr];
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        av, aw;
    logic [7:0]  am, aa;
    logic [63:0] ad;
    logic        bv, bw;
    logic [7:0]  bm, ba;
    logic [63:0] bd;
    logic        ar, br;
    logic        arv;
    logic [63:0] ard;
    logic        brv;
    logic [63:0] brd;
  } vec_t;

  vec_t vt [40];
  int   nrows = 0;

  task automatic add_row(input logic av, input logic aw, input logic [7:0] am, input logic [7:0] aa,
                         input logic [63:0] ad, input logic bv, input logic bw, input logic [7:0] bm,
                         input logic [7:0] ba, input logic [63:0] bd, input logic ar, input logic br);
    vt[nrows].av = av; vt[nrows].aw = aw; vt[nrows].am = am; vt[nrows].aa = aa; vt[nrows].ad = ad;
    vt[nrows].bv = bv; vt[nrows].bw = bw; vt[nrows].bm = bm; vt[nrows].ba = ba; vt[nrows].bd = bd;
    vt[nrows].ar = ar; vt[nrows].br = br;
    nrows++;
  endtask

  task automatic exp_a(input int r, input logic [63:0] d);
    vt[r].arv = 1'b1; vt[r].ard = d;
  endtask

  task automatic exp_b(input int r, input logic [63:0] d);
    vt[r].brv = 1'b1; vt[r].brd = d;
  endtask

  localparam logic [63:0] DB = 64'hDEADBEEF_01234567;
  localparam logic [63:0] BP = 64'hB0B0_0000_0000_0000;

  initial begin
    int   done_at;
    logic saw_rv;

    // Vector table: rows are applied one per cycle; responses land three rows after accept.
    for (int i = 0; i < 40; i++) vt[i] = '{default: 0};
    add_row(1, 1, 8'hFF, 8'h10, DB, 0, 0, 0, 0, 0, 1, 0);          // r0 A write 0x10
    add_row(1, 0, 8'hFF, 8'h10, 0,  0, 0, 0, 0, 0, 1, 0);          // r1 A read 0x10
    exp_a(4, DB);
    add_row(1, 1, 8'hFF, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 1, 0); // r2
    add_row(1, 1, 8'h0F, 8'h05, 64'h0, 0, 0, 0, 0, 0, 1, 0);       // r3 masked write
    add_row(1, 0, 8'hFF, 8'h05, 0,     0, 0, 0, 0, 0, 1, 0);       // r4 read back
    exp_a(7, 64'hFFFF_FFFF_0000_0000);
    for (int j = 0; j < 8; j++)                                    // r5..r12 B writes
      add_row(0, 0, 0, 0, 0, 1, 1, 8'hFF, 8'(j), BP | 64'(j), 0, 1);
    for (int j = 0; j < 8; j++) begin                              // r13..r28 contention
      exp_a(nrows + 3, DB);
      add_row(1, 0, 8'hFF, 8'h10, 0, 1, 0, 8'hFF, 8'(j), 0, 1, 0);
      exp_b(nrows + 3, BP | 64'(j));
      add_row(1, 0, 8'hFF, 8'h10, 0, 1, 0, 8'hFF, 8'(j), 0, 0, 1);
    end
    for (int j = 0; j < 3; j++) add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state, with both requesters asserting valid.
    rst_n = 1'b0;
    a_valid = 1; a_we = 0; a_wmask = 0; a_addr = 0; a_wdata = 0;
    b_valid = 1; b_we = 0; b_wmask = 0; b_addr = 0; b_wdata = 0;
    repeat (2) @(negedge clk0);
    #1;
    chk("rst_csb0", csb0, 1);      chk("rst_web0", web0, 1);
    chk("rst_wmask0", wmask0, 0);  chk("rst_addr0", addr0, 0);
    chk("rst_din0", din0, 0);      chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0); chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0); chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0); chk("rst_init_done", init_done, 0);

    // Zero-fill sequence.
    @(negedge clk0); rst_n = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk0); #1;
      chk($sformatf("init_csb0[%0d]", k), csb0, 0);
      chk($sformatf("init_web0[%0d]", k), web0, 0);
      chk($sformatf("init_wmask0[%0d]", k), wmask0, 8'hFF);
      chk($sformatf("init_addr0[%0d]", k), addr0, 64'(k));
      chk($sformatf("init_din0[%0d]", k), din0, 0);
      chk($sformatf("init_a_ready[%0d]", k), a_ready, (k == 255));
      chk($sformatf("init_b_ready[%0d]", k), b_ready, 0);
      chk($sformatf("init_done[%0d]", k), init_done, (k == 255));
    end
    a_valid = 0; b_valid = 0;

    for (int i = 0; i < nrows; i++) begin
      @(negedge clk0);
      a_valid = vt[i].av; a_we = vt[i].aw; a_wmask = vt[i].am; a_addr = vt[i].aa; a_wdata = vt[i].ad;
      b_valid = vt[i].bv; b_we = vt[i].bw; b_wmask = vt[i].bm; b_addr = vt[i].ba; b_wdata = vt[i].bd;
      #1;
      chk($sformatf("a_ready[%0d]", i), a_ready, vt[i].ar);
      chk($sformatf("b_ready[%0d]", i), b_ready, vt[i].br);
      chk($sformatf("a_rvalid[%0d]", i), a_rvalid, vt[i].arv);
      chk($sformatf("b_rvalid[%0d]", i), b_rvalid, vt[i].brv);
      if (vt[i].arv) chk($sformatf("a_rdata[%0d]", i), a_rdata, vt[i].ard);
      if (vt[i].brv) chk($sformatf("b_rdata[%0d]", i), b_rdata, vt[i].brd);
      if (i > 0 && (vt[i-1].ar || vt[i-1].br)) begin
        chk($sformatf("csb0[%0d]", i), csb0, 0);
        chk($sformatf("web0[%0d]", i), web0, vt[i-1].ar ? !vt[i-1].aw : !vt[i-1].bw);
        chk($sformatf("addr0[%0d]", i), addr0, vt[i-1].ar ? vt[i-1].aa : vt[i-1].ba);
        chk($sformatf("wmask0[%0d]", i), wmask0, vt[i-1].ar ? vt[i-1].am : vt[i-1].bm);
        if (vt[i-1].ar && vt[i-1].aw) chk($sformatf("din0[%0d]", i), din0, vt[i-1].ad);
        if (vt[i-1].br && vt[i-1].bw) chk($sformatf("din0[%0d]", i), din0, vt[i-1].bd);
      end else begin
        chk($sformatf("csb0_idle[%0d]", i), csb0, 1);
        chk($sformatf("web0_idle[%0d]", i), web0, 1);
      end
    end

    // Reset one cycle after a read accept: read is dropped and the array is re-zeroed.
    @(negedge clk0);
    a_valid = 1; a_we = 1; a_addr = 8'h30; a_wdata = 64'h55; a_wmask = 8'hFF;
    @(negedge clk0);
    a_we = 0;
    #1 chk("t5_rd_ready", a_ready, 1);
    @(posedge clk0); #1 a_valid = 0;
    @(posedge clk0); #1 rst_n = 1'b0; a_valid = 1;
    #1;
    chk("t5_csb0", csb0, 1);
    chk("t5_a_ready", a_ready, 0);
    chk("t5_init_done", init_done, 0);
    chk("t5_a_rvalid", a_rvalid, 0);
    saw_rv = 1'b0;
    repeat (2) @(negedge clk0) if (a_rvalid) saw_rv = 1'b1;
    rst_n = 1'b1; a_valid = 0;
    done_at = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk0); #1;
      if (a_rvalid) saw_rv = 1'b1;
      if (init_done) begin
        done_at = c;
        break;
      end
    end
    chk("t5_init_cycles", 64'(done_at), 64'(255));
    chk("t5_no_rvalid", saw_rv, 0);
    a_valid = 1; a_we = 0; a_addr = 8'h30;
    #1 chk("t5_ready_after_init", a_ready, 1);
    @(negedge clk0); a_valid = 0;
    repeat (2) @(negedge clk0);
    #1;
    chk("t5_rvalid", a_rvalid, 1);
    chk("t5_rdata_zeroed", a_rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
